ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset), over the same open-collector clock/data pair that the keyboard receiver listens on. It runs in the clk_50 domain alongside the keyboard receiver. It asserts tx_active so the receiver ignores line activity while a host transfer is in progress.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time before the request (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, max wait from clock release to the first device falling edge (15 ms).
BIT_TIMEOUT_CYCLES, 100000, max gap between consecutive device falling edges (2 ms).
TIMER_W, 20, timer width; must hold the largest cycle parameter.

Ports:
clk  input  1  system clock (clk_50 domain).
RST  input  1  asynchronous active-low reset.
tx_data  input  8  byte to send.
tx_valid  input  1  request to send tx_data.
tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid & tx_ready.
ps2_clk_d  input  1  raw PS/2 clock line level.
ps2_data_d  input  1  raw PS/2 data line level.
ps2_clk_q  output  1  1 = pull PS/2 clock low, 0 = release.
ps2_data_q  output  1  1 = pull PS/2 data low, 0 = release.
tx_active  output  1  high in every state except IDLE; receiver gate.
done  output  1  one-cycle pulse on acknowledged completion.
error  output  1  one-cycle pulse on failure.
err_code  output  2  00 none, 01 start timeout, 10 bit timeout, 11 NACK; holds until next accept.

Behaviour:
- Synchronization: ps2_clk_d and ps2_data_d pass through 2-flop synchronizers. A device falling edge (fe) is synchronized clock 1 -> 0.
- Reset (RST low, asynchronous): state IDLE; ps2_clk_q=0, ps2_data_q=0; tx_ready=1; tx_active=0; done=0; error=0; err_code=00; timer and bit count cleared. Reset mid-transfer releases both lines immediately.
- Accept: the cycle after the handshake, latch tx_data, compute odd parity (parity = ~^tx_data), clear err_code, and enter INHIBIT. tx_valid outside IDLE is ignored and not queued.
- INHIBIT: ps2_clk_q=1, ps2_data_q=0, for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle): ps2_clk_q=1, ps2_data_q=1 (start bit). Then go to WAIT_FIRST with ps2_clk_q=0, ps2_data_q held 1, timer cleared.
- WAIT_FIRST: on fe, drive D0 (ps2_data_q = ~bit), set bit_idx=1, and go to SHIFT. If the timer reaches START_TIMEOUT_CYCLES, go to FAIL with code 01.
- SHIFT: each fe advances the output.
  - fe 2..8 drive D1..D7 (LSB first).
  - fe 9 drives parity.
  - fe 10 releases data (stop bit) and goes to ACK.
  - The timer clears on every fe; reaching BIT_TIMEOUT_CYCLES goes to FAIL with code 10.
- ACK: on fe 11, sample synchronized data. Low = ACK, go to WAIT_IDLE. High = FAIL with code 11. The bit timeout also applies here (code 10).
- WAIT_IDLE: wait until synchronized clock=1 and data=1, then pulse done and go to IDLE. The bit timeout applies (code 10).
- FAIL (1 cycle): release both lines, pulse error, latch err_code, go to IDLE.
- done and error are never both high, and exactly one pulses per accepted byte.
- tx_active = (state != IDLE).
- Bit counter is 4 bits; the timer saturates rather than wrapping.

Optional Feature:
PS2_TX_FILTER_EN
- Defined: fe is recognized only after the synchronized clock has been low for 8 consecutive clk cycles following a high period. Pulses shorter than 8 cycles are ignored. Edge-to-data-drive latency becomes 2+8 cycles.
- Undefined: fe is the raw synchronized 1 -> 0 transition, with 2-3 cycles latency.

Test Plan:
- Send 0xED; device model clocks at ~12 kHz and ACKs -> clock held low exactly 5000 cycles; data bits seen on rising edges are 0 (start),1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err_code=00.
- Send 0xF4 -> parity bit 0; done pulses; tx_ready returns to 1 only after both lines idle high.
- Device leaves data high at fe 11 -> error pulse, err_code=11, no done, lines released.
- Device never clocks -> error exactly START_TIMEOUT_CYCLES (+sync latency) after clock release, err_code=01.
- Device stops after fe 4 -> error after BIT_TIMEOUT_CYCLES, err_code=10; next tx_valid accepted normally.
- Pulse tx_valid while busy; assert RST mid-SHIFT -> busy request ignored; during reset ps2_clk_q=ps2_data_q=0 asynchronously, outputs at reset values, no done/error pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (clk_50 domain).
// Inhibits the bus, issues a request-to-send, and then shifts a byte out
// on the device-generated clock: eight data bits LSB first, odd parity,
// and a stop bit. It then checks the device ACK and waits for the bus to
// return to idle. tx_active gates the keyboard receiver for the whole transfer.
// Optional build macro PS2_TX_FILTER_EN: a device falling edge counts only
// after the synchronized clock has been low for 8 consecutive cycles.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BIT_TIMEOUT_CYCLES   = 100000,
  parameter int TIMER_W              = 20
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_d,
  input  logic       ps2_data_d,
  output logic       ps2_clk_q,
  output logic       ps2_data_q,
  output logic       tx_active,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_BIT   = 2'b10;
  localparam logic [1:0] ERR_NACK  = 2'b11;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LIMIT  = TIMER_W'(START_TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] BIT_LIMIT    = TIMER_W'(BIT_TIMEOUT_CYCLES);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         w_fail_code;
  logic               r_clk_s1, r_clk_s2;
  logic               r_data_s1, r_data_s2;
  logic               w_fe;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_bit_idx;
  logic [8:0]         r_shift;
  logic [1:0]         r_err_code;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && tx_valid;

  // Two-flop synchronizers for the raw bus levels.
  // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset cannot fake a falling edge.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_clk_s1  <= ps2_clk_d;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= ps2_data_d;
      r_data_s2 <= r_data_s1;
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic [2:0] r_low_cnt;
  logic       r_armed;

  // Glitch filter: re-arm on a high level, fire once on the 8th consecutive low cycle.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_low_cnt <= 3'd0;
      r_armed   <= 1'b1;
    end else if (r_clk_s2) begin
      r_low_cnt <= 3'd0;
      r_armed   <= 1'b1;
    end else if (r_armed) begin
      if (r_low_cnt == 3'd7) r_armed <= 1'b0;
      else                   r_low_cnt <= r_low_cnt + 3'd1;
    end
  end

  assign w_fe = r_armed && !r_clk_s2 && (r_low_cnt == 3'd7);
`else
  logic r_clk_prev;

  // Previous synchronized clock level for plain 1 -> 0 edge detection.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_clk_prev <= 1'b1;
    else      r_clk_prev <= r_clk_s2;
  end

  assign w_fe = r_clk_prev && !r_clk_s2;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next-state logic, including which failure code a FAIL entry carries.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    w_state_next = r_state;
    w_fail_code  = ERR_NONE;
    unique case (r_state)
      S_IDLE:       if (w_accept) w_state_next = S_INHIBIT;
      S_INHIBIT:    if (r_timer == INHIBIT_LAST) w_state_next = S_REQ;
      S_REQ:        w_state_next = S_WAIT_FIRST;
      S_WAIT_FIRST: begin
        if (w_fe) w_state_next = S_SHIFT;
        else if (r_timer == START_LIMIT) begin
          w_state_next = S_FAIL;
          w_fail_code  = ERR_START;
        end
      end
      S_SHIFT: begin
        if (w_fe) begin
          if (r_bit_idx == 4'd9) w_state_next = S_ACK;
        end else if (r_timer == BIT_LIMIT) begin
          w_state_next = S_FAIL;
          w_fail_code  = ERR_BIT;
        end
      end
      S_ACK: begin
        if (w_fe) begin
          if (r_data_s2) begin
            w_state_next = S_FAIL;
            w_fail_code  = ERR_NACK;
          end else begin
            w_state_next = S_WAIT_IDLE;
          end
        end else if (r_timer == BIT_LIMIT) begin
          w_state_next = S_FAIL;
          w_fail_code  = ERR_BIT;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clk_s2 && r_data_s2) w_state_next = S_IDLE;
        else if (r_timer == BIT_LIMIT) begin
          w_state_next = S_FAIL;
          w_fail_code  = ERR_BIT;
        end
      end
      S_FAIL:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: phase timer, frame shifter, bit counter and sticky error code.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_timer    <= '0;
      r_bit_idx  <= 4'd0;
      r_shift    <= 9'd0;
      r_err_code <= ERR_NONE;
    end else begin
      // Timer restarts on every phase change and on each device edge while shifting;
      // only edges in SHIFT matter, our own inhibit pull-down also looks like an edge.
      if ((w_state_next != r_state) || (w_fe && (r_state == S_SHIFT)))
        r_timer <= '0;
      else if (r_timer != '1)
        r_timer <= r_timer + TIMER_W'(1);

      if (w_accept) begin
        r_shift    <= {~^tx_data, tx_data};
        r_bit_idx  <= 4'd0;
        r_err_code <= ERR_NONE;
      end else if (w_fe && (r_state == S_WAIT_FIRST)) begin
        r_bit_idx <= 4'd1;
      end else if (w_fe && (r_state == S_SHIFT)) begin
        r_shift   <= {1'b0, r_shift[8:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end

      if (w_state_next == S_FAIL) r_err_code <= w_fail_code;
    end
  end

  // FSM outputs: line drivers, handshake and completion pulses.
  always_comb begin
    ps2_clk_q  = 1'b0;
    ps2_data_q = 1'b0;
    tx_ready   = 1'b0;
    tx_active  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        tx_ready  = 1'b1;
        tx_active = 1'b0;
      end
      S_INHIBIT: ps2_clk_q = 1'b1;
      S_REQ: begin
        ps2_clk_q  = 1'b1;
        ps2_data_q = 1'b1;
      end
      S_WAIT_FIRST: ps2_data_q = 1'b1;
      S_SHIFT:      ps2_data_q = ~r_shift[0];
      S_WAIT_IDLE:  done = r_clk_s2 && r_data_s2;
      S_FAIL:       error = 1'b1;
      default:      ;
    endcase
  end

  assign err_code = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with an open-collector
// PS/2 device model, a per-cycle transaction-level checker and directed plus
// randomized transfers. Timeouts are shortened through parameters.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int STO = 300;
  localparam int BTO = 200;
  localparam int TW  = 12;
`ifdef PS2_TX_FILTER_EN
  localparam int FE_LAT = 10;  // 2 sync + 8 low cycles
`else
  localparam int FE_LAT = 3;   // 2 sync + edge detect
`endif

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clk_q, ps2_data_q, tx_active, done, error;
  logic [1:0] err_code;
  logic       dev_clk_rel, dev_data_rel;
  logic       ps2_clk_d, ps2_data_d;

  // Open-collector bus: line is high only if neither side pulls it low.
  assign ps2_clk_d  = dev_clk_rel  & ~ps2_clk_q;
  assign ps2_data_d = dev_data_rel & ~ps2_data_q;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO),
    .BIT_TIMEOUT_CYCLES(BTO), .TIMER_W(TW)
  ) dut (
    .clk(clk), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_d(ps2_clk_d), .ps2_data_d(ps2_data_d), .ps2_clk_q(ps2_clk_q),
    .ps2_data_q(ps2_data_q), .tx_active(tx_active), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy from accept through the done/error pulse.
  bit         m_busy = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic [1:0] m_exp_code = 2'b00;
  int         m_done_cnt = 0;
  int         m_err_cnt = 0;
  int         m_pulse_cyc = 0;

  always @(negedge clk) begin
    if (!RST) begin
      check("rst_outputs", {tx_ready, tx_active, ps2_clk_q, ps2_data_q, done, error},
            6'b100000);
      check("rst_err_code", err_code, 2'b00);
      m_busy = 1'b0;
      m_code = 2'b00;
    end else begin
      check("tx_ready", tx_ready, !m_busy);
      check("tx_active", tx_active, m_busy);
      check("done_error_excl", done & error, 1'b0);
      if (!m_busy) check("idle_quiet", {ps2_clk_q, ps2_data_q, done, error}, 4'b0000);
      if (done) check("done_lines_idle", {ps2_clk_d, ps2_data_d}, 2'b11);
      if (error) m_code = m_exp_code;
      check("err_code", err_code, m_code);
      if (done)  m_done_cnt++;
      if (error) m_err_cnt++;
      if (done || error) m_pulse_cyc = cyc;
      if (m_busy && (done || error)) m_busy = 1'b0;
      else if (!m_busy && tx_valid) begin
        m_busy = 1'b1;
        m_code = 2'b00;
      end
    end
  end

  // Expected 11-bit frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Count inhibit (clock only) and request (clock+data) cycles; return release cycle.
  task automatic measure_inhibit(output int inh, output int req, output int rel);
    int guard = 0;
    inh = 0;
    req = 0;
    while (ps2_clk_q && !ps2_data_q && guard < 4 * INH) begin inh++; guard++; step(); end
    while (ps2_clk_q && ps2_data_q && guard < 4 * INH) begin req++; guard++; step(); end
    rel = cyc;
  endtask

  // Device model: n_fe clock pulses, data sampled on each rising edge, optional ACK.
  task automatic device(input int n_fe, input bit ack, output logic [10:0] seen,
                        output int last_fe, output int rel_data);
    int hp = $urandom_range(12, 25);
    seen = '1;
    last_fe = 0;
    rel_data = 0;
    repeat (hp) step();
    seen[0] = ps2_data_d;
    for (int k = 1; k <= n_fe; k++) begin
      if (k == 11 && ack) begin
        dev_data_rel = 1'b0;
        repeat (2) step();
      end
      dev_clk_rel = 1'b0;
      last_fe = cyc;
      repeat (hp) step();
      dev_clk_rel = 1'b1;
      if (k <= 10) seen[k] = ps2_data_d;
      repeat (hp) step();
    end
    dev_data_rel = 1'b1;
    rel_data = cyc;
  endtask

  // mode: 0 = ACK, 1 = NACK, 2 = device never clocks, 3 = device stops after fe 4
  task automatic send(input logic [7:0] b, input int mode, output logic [10:0] seen);
    int d0, e0, inh, req, rel, last_fe, rel_data, guard;
    logic [10:0] exp;
    d0 = m_done_cnt;
    e0 = m_err_cnt;
    seen = '1;
    last_fe = 0;
    rel_data = 0;
    exp = model_frame(b);
    m_exp_code = (mode == 1) ? 2'b11 : (mode == 2) ? 2'b01 : (mode == 3) ? 2'b10 : 2'b00;
    start_tx(b);
    measure_inhibit(inh, req, rel);
    check("inhibit_len", inh, INH);
    check("req_len", req, 1);
    check("start_bit_held", {ps2_clk_q, ps2_data_q}, 2'b01);
    case (mode)
      0: device(11, 1'b1, seen, last_fe, rel_data);
      1: device(11, 1'b0, seen, last_fe, rel_data);
      3: begin
        device(4, 1'b1, seen, last_fe, rel_data);
        tx_data  = ~b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
      end
      default: ;
    endcase
    guard = 0;
    while (m_done_cnt + m_err_cnt == d0 + e0 && guard < 2 * STO + 2 * BTO) begin
      guard++;
      step();
    end
    check("pulse_seen", (m_done_cnt + m_err_cnt != d0 + e0), 1'b1);
    repeat (20) step();
    check("done_count", m_done_cnt - d0, (mode == 0) ? 1 : 0);
    check("error_count", m_err_cnt - e0, (mode == 0) ? 0 : 1);
    check("err_code_hold", err_code, m_exp_code);
    case (mode)
      0: begin
        check("frame", seen, exp);
        check("done_latency", m_pulse_cyc - rel_data, 2);
      end
      1: check("frame_nack", seen, exp);
      2: check("start_timeout_lat", m_pulse_cyc - rel, STO + 1);
      default: begin
        check("frame_partial", seen[4:0], exp[4:0]);
        check("bit_timeout_lat", m_pulse_cyc - last_fe, BTO + FE_LAT + 1);
      end
    endcase
  endtask

  task automatic reset_mid_shift(input logic [7:0] b);
    int d0, e0, inh, req, rel, last_fe, rel_data;
    logic [10:0] seen;
    d0 = m_done_cnt;
    e0 = m_err_cnt;
    m_exp_code = 2'b00;
    start_tx(b);
    measure_inhibit(inh, req, rel);
    device(3, 1'b1, seen, last_fe, rel_data);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("async_rst_lines", {ps2_clk_q, ps2_data_q}, 2'b00);
    check("async_rst_status", {tx_ready, tx_active, done, error}, 4'b1000);
    repeat (4) step();
    RST = 1'b1;
    repeat (20) step();
    check("rst_no_done", m_done_cnt - d0, 0);
    check("rst_no_error", m_err_cnt - e0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] seen;
    logic [7:0]  b;
    RST = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_rel = 1'b1;
    dev_data_rel = 1'b1;
    #1 RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    step();

    send(8'hED, 0, seen);
    check("frame_ED_literal", seen, 11'h7DA);
    send(8'hF4, 0, seen);
    check("frame_F4_literal", seen, 11'h5E8);
    send(8'hF4, 1, seen);
    send(8'hFF, 2, seen);
    send(8'hF4, 3, seen);
    send(8'h5A, 0, seen);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send(b, 0, seen);
    end
    reset_mid_shift(8'hA5);
    b = 8'($urandom);
    send(b, 0, seen);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
